// File: rtl/jtvigil_pkg.sv
// Shared constants for the Vigilante video blocks: SCR2 register map, layer width, FSM states.
package jtvigil_pkg;

    localparam logic [2:0] SCR2_SCRL_LO = 3'd0;
    localparam logic [2:0] SCR2_SCRL_HI = 3'd1;
    localparam logic [2:0] SCR2_CTRL    = 3'd4;

    localparam int unsigned SCR2_W            = 2048;
    localparam int unsigned SCR2_CTRL_ENB_BIT = 6;

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StNext,
        StRun
    } scr2_st_e;

endpackage

// File: rtl/jtvigil_scr2_if.sv
// SDRAM ROM fetch port of the SCR2 renderer: word address/request out, data/valid back.
interface jtvigil_scr2_if;

    logic [15:0] rom_addr;
    logic        rom_cs;
    logic        rom_ok;
    logic [31:0] rom_data;

    modport master (
        output rom_addr,
        output rom_cs,
        input  rom_ok,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  rom_cs,
        output rom_ok,
        output rom_data
    );

endinterface

// File: rtl/jtvigil_scr2_shift.sv
// SCR2 pixel serialiser: 32-bit 4bpp shift register with load-time pre-shift and pixel counter.
module jtvigil_scr2_shift (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  skip_i,
    input  logic        shift_i,
    output logic [3:0]  pxl_o,
    output logic        last_o
);

    logic [31:0] shreg_q;
    logic [2:0]  cnt_q;

    // A load starts the counter at the skipped pixel count so the word boundary stays aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            shreg_q <= data_i << {skip_i, 2'b00};
            cnt_q   <= skip_i;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[27:0], 4'h0};
            cnt_q   <= cnt_q + 3'd1;
        end
    end

    assign pxl_o  = shreg_q[31:28];
    assign last_o = (cnt_q == 3'd7);

endmodule

// File: rtl/jtvigil_scr2.sv
// Vigilante rear background (SCR2): scroll/colour registers, ROM word prefetch, pixel output.
// Optional JTVIGIL_SCR2_DEBUG_EN adds the st_dout underrun counter and the gfx_dis input.
module jtvigil_scr2
    import jtvigil_pkg::*;
#(
    parameter int HOFFSET = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pxl_cen,
    input  logic           LHBL,
    input  logic [7:0]     vdump,
    input  logic [2:0]     main_addr,
    input  logic [7:0]     main_dout,
    input  logic           main_rnw,
    input  logic           scr2_cs,
    jtvigil_scr2_if.master rom,
    output logic [3:0]     scr2_pxl,
    output logic [2:0]     scr2col,
    output logic           scr2enb
`ifdef JTVIGIL_SCR2_DEBUG_EN
    ,
    input  logic           gfx_dis,
    output logic [7:0]     st_dout
`endif
);

    localparam int unsigned XW = $clog2(SCR2_W);

    scr2_st_e    st_q, st_d;
    logic        lhbl_q;
    logic [7:0]  vline_q, vline_d;
    logic [XW-1:0] x_q, x_d;
    logic        rom_cs_q, rom_cs_d;
    logic        nvalid_q, nvalid_d;
    logic [31:0] next_q, next_d;
    logic [10:0] hscroll_q;
    logic [2:0]  col_q;
    logic        enb_q;
    logic [3:0]  pxl_q;

    logic [XW-1:0] hoff;
    logic        lhbl_fall, accept, pix_step, wrap, pxl_mask;
    logic        sh_load, sh_last;
    logic [31:0] sh_data;
    logic [2:0]  sh_skip;
    logic [3:0]  sh_pxl;

    assign hoff      = HOFFSET[XW-1:0];
    assign lhbl_fall = lhbl_q & ~LHBL;
    assign accept    = rom_cs_q & rom.rom_ok;
    assign pix_step  = pxl_cen & LHBL & ((st_q == StNext) | (st_q == StRun));
    assign wrap      = pix_step & sh_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hscroll_q <= '0;
            col_q     <= '0;
            enb_q     <= 1'b0;
        end else if (scr2_cs && !main_rnw) begin
            case (main_addr)
                SCR2_SCRL_LO: hscroll_q[7:0]  <= main_dout;
                SCR2_SCRL_HI: hscroll_q[10:8] <= main_dout[2:0];
                SCR2_CTRL: begin
                    col_q <= main_dout[2:0];
                    enb_q <= main_dout[SCR2_CTRL_ENB_BIT];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= StIdle;
            lhbl_q   <= 1'b0;
            vline_q  <= '0;
            x_q      <= '0;
            rom_cs_q <= 1'b0;
            nvalid_q <= 1'b0;
            next_q   <= '0;
        end else begin
            st_q     <= st_d;
            lhbl_q   <= LHBL;
            vline_q  <= vline_d;
            x_q      <= x_d;
            rom_cs_q <= rom_cs_d;
            nvalid_q <= nvalid_d;
            next_q   <= next_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        vline_d  = vline_q;
        x_d      = x_q;
        rom_cs_d = rom_cs_q;
        nvalid_d = nvalid_q;
        next_d   = next_q;
        sh_load  = 1'b0;
        sh_data  = rom.rom_data;
        sh_skip  = 3'd0;
        if (lhbl_fall) begin
            // Dropping rom_cs here abandons any fetch still in flight.
            st_d     = StFirst;
            vline_d  = vdump;
            x_d      = hscroll_q + hoff;
            rom_cs_d = 1'b0;
            nvalid_d = 1'b0;
        end else begin
            case (st_q)
                StIdle: ;
                StFirst: begin
                    if (accept) begin
                        sh_load  = 1'b1;
                        sh_skip  = x_q[2:0];
                        x_d      = x_q + XW'(8);
                        rom_cs_d = 1'b0;
                        st_d     = StNext;
                    end else begin
                        rom_cs_d = 1'b1;
                    end
                end
                StNext: begin
                    if (accept) begin
                        next_d   = rom.rom_data;
                        nvalid_d = 1'b1;
                        rom_cs_d = 1'b0;
                        st_d     = StRun;
                    end else begin
                        rom_cs_d = 1'b1;
                    end
                    // Word boundary before the fetch landed: emit zeros and refetch at the new x.
                    if (wrap) begin
                        sh_load  = 1'b1;
                        sh_data  = accept ? rom.rom_data : 32'd0;
                        x_d      = x_q + XW'(8);
                        rom_cs_d = 1'b0;
                        nvalid_d = 1'b0;
                        st_d     = StNext;
                    end
                end
                StRun: begin
                    if (wrap) begin
                        sh_load  = 1'b1;
                        sh_data  = nvalid_q ? next_q : 32'd0;
                        x_d      = x_q + XW'(8);
                        nvalid_d = 1'b0;
                        st_d     = StNext;
                    end
                end
                default: st_d = StIdle;
            endcase
        end
    end

    jtvigil_scr2_shift u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (sh_load),
        .data_i  (sh_data),
        .skip_i  (sh_skip),
        .shift_i (pix_step),
        .pxl_o   (sh_pxl),
        .last_o  (sh_last)
    );

`ifdef JTVIGIL_SCR2_DEBUG_EN
    logic [7:0] unrun_q;
    logic       underrun;

    assign underrun = (st_q == StNext) & wrap & ~accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unrun_q <= '0;
        end else if (underrun && unrun_q != 8'hFF) begin
            unrun_q <= unrun_q + 8'd1;
        end
    end

    assign st_dout  = unrun_q;
    assign pxl_mask = ~gfx_dis;
`else
    assign pxl_mask = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pxl_q <= '0;
        end else if (!LHBL) begin
            pxl_q <= '0;
        end else if (pxl_cen) begin
            pxl_q <= (pix_step && pxl_mask) ? sh_pxl : 4'd0;
        end
    end

    assign rom.rom_cs   = rom_cs_q;
    assign rom.rom_addr = {vline_q, x_q[XW-1:3]};
    assign scr2_pxl     = pxl_q;
    assign scr2col      = col_q;
    assign scr2enb      = enb_q;

endmodule

// File: tb/tb_jtvigil_scr2.sv
// Directed bench for jtvigil_scr2: ROM responder with stall control and a pixel reference model.
module tb_jtvigil_scr2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl_cen = 1'b0;
    logic       LHBL = 1'b1;
    logic [7:0] vdump = '0;
    logic [2:0] main_addr = '0;
    logic [7:0] main_dout = '0;
    logic       main_rnw = 1'b1;
    logic       scr2_cs = 1'b0;
    logic [3:0] scr2_pxl;
    logic [2:0] scr2col;
    logic       scr2enb;
    logic       stall = 1'b0;
`ifdef JTVIGIL_SCR2_DEBUG_EN
    logic       gfx_dis = 1'b0;
    logic [7:0] st_dout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    jtvigil_scr2_if rom_if ();

    jtvigil_scr2 #(
        .HOFFSET (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pxl_cen   (pxl_cen),
        .LHBL      (LHBL),
        .vdump     (vdump),
        .main_addr (main_addr),
        .main_dout (main_dout),
        .main_rnw  (main_rnw),
        .scr2_cs   (scr2_cs),
        .rom       (rom_if.master),
        .scr2_pxl  (scr2_pxl),
        .scr2col   (scr2col),
        .scr2enb   (scr2enb)
`ifdef JTVIGIL_SCR2_DEBUG_EN
        ,
        .gfx_dis   (gfx_dis),
        .st_dout   (st_dout)
`endif
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        pxl_cen = ~pxl_cen;
    end

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        if (a == 16'h0500) return 32'h1234_5678;
        return {a[7:0], a[15:8], 8'h5A ^ a[7:0], 8'hC3} ^ 32'h1111_1111;
    endfunction

    function automatic logic [3:0] exp_pix(input logic [7:0] l, input logic [10:0] x);
        logic [31:0] w;
        w = rom_word({l, x[10:3]});
        return w[31 - 4 * int'(x[2:0]) -: 4];
    endfunction

    // ROM responder: data valid two cycles after request unless stalled.
    initial begin
        int lat;
        lat = 0;
        rom_if.rom_ok   = 1'b0;
        rom_if.rom_data = '0;
        forever begin
            @(negedge clk);
            if (!rom_if.rom_cs) begin
                rom_if.rom_ok = 1'b0;
                lat = 0;
            end else if (stall) begin
                rom_if.rom_ok = 1'b0;
            end else if (lat >= 2) begin
                rom_if.rom_ok   = 1'b1;
                rom_if.rom_data = rom_word(rom_if.rom_addr);
            end else begin
                lat++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        scr2_cs   = 1'b1;
        main_addr = a;
        main_dout = d;
        main_rnw  = 1'b0;
        @(negedge clk);
        scr2_cs   = 1'b0;
        main_rnw  = 1'b1;
    endtask

    task automatic run_line(input logic [7:0] l, input logic [10:0] scr, input int npix,
                            input int stall_at, input int zlo, input int zhi, input int wr_at);
        logic [10:0] xk;
        @(negedge clk);
        LHBL  = 1'b0;
        vdump = l;
        repeat (40) @(negedge clk);
        check_eq($sformatf("blank l%0d", l), 32'(scr2_pxl), 32'd0);
        LHBL = 1'b1;
        for (int k = 0; k < npix; k++) begin
            @(posedge clk);
            while (!pxl_cen) @(posedge clk);
            #1;
            xk = scr + 11'(k);
            if (k >= zlo && k <= zhi)
                check_eq($sformatf("pxl l%0d k%0d", l, k), 32'(scr2_pxl), 32'd0);
            else
                check_eq($sformatf("pxl l%0d k%0d", l, k), 32'(scr2_pxl), 32'(exp_pix(l, xk)));
            if (k == stall_at) stall = 1'b1;
            if (k == stall_at + 10) stall = 1'b0;
            if (k == wr_at) begin
                scr2_cs   = 1'b1;
                main_addr = 3'd0;
                main_dout = 8'h20;
                main_rnw  = 1'b0;
                @(posedge clk);
                #1;
                scr2_cs  = 1'b0;
                main_rnw = 1'b1;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst rom_cs", 32'(rom_if.rom_cs), 32'd0);
        check_eq("rst rom_addr", 32'(rom_if.rom_addr), 32'd0);
        check_eq("rst pxl", 32'(scr2_pxl), 32'd0);
        check_eq("rst col", 32'(scr2col), 32'd0);
        check_eq("rst enb", 32'(scr2enb), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("idle rom_cs", 32'(rom_if.rom_cs), 32'd0);

        // Scroll 0, mid-line scroll write must not disturb this line.
        run_line(8'd5, 11'h000, 24, -1, 99, -1, 4);
        run_line(8'd6, 11'h020, 16, -1, 99, -1, -1);
        cpu_wr(3'd0, 8'h05);
        run_line(8'd7, 11'h005, 16, -1, 99, -1, -1);
        cpu_wr(3'd0, 8'hFC);
        cpu_wr(3'd1, 8'h07);
        run_line(8'd5, 11'h7FC, 16, -1, 99, -1, -1);
        cpu_wr(3'd0, 8'h00);
        cpu_wr(3'd1, 8'h00);
        // Col 2 fetch withheld for 10 pixel periods: pixels 16..23 blank, col 3 realigned.
        run_line(8'd9, 11'h000, 32, 7, 16, 23, -1);
`ifdef JTVIGIL_SCR2_DEBUG_EN
        check_eq("st_dout", 32'(st_dout), 32'd1);
`endif

        cpu_wr(3'd4, 8'h45);
        check_eq("ctrl col", 32'(scr2col), 32'd5);
        check_eq("ctrl enb", 32'(scr2enb), 32'd1);
        cpu_wr(3'd2, 8'h02);
        check_eq("ignored ofs col", 32'(scr2col), 32'd5);
        @(negedge clk);
        scr2_cs   = 1'b1;
        main_addr = 3'd4;
        main_dout = 8'h00;
        main_rnw  = 1'b1;
        @(negedge clk);
        scr2_cs = 1'b0;
        check_eq("read ignored enb", 32'(scr2enb), 32'd1);
        cpu_wr(3'd4, 8'h03);
        check_eq("ctrl col2", 32'(scr2col), 32'd3);
        check_eq("ctrl enb2", 32'(scr2enb), 32'd0);
        cpu_wr(3'd4, 8'h45);

        // Reset in the middle of a pending fetch.
        stall = 1'b1;
        @(negedge clk);
        LHBL  = 1'b0;
        vdump = 8'd3;
        repeat (6) @(negedge clk);
        check_eq("pending cs", 32'(rom_if.rom_cs), 32'd1);
        check_eq("pending addr", 32'(rom_if.rom_addr), 32'h0300);
        rst_n = 1'b0;
        #1;
        check_eq("mid rst cs", 32'(rom_if.rom_cs), 32'd0);
        check_eq("mid rst addr", 32'(rom_if.rom_addr), 32'd0);
        check_eq("mid rst pxl", 32'(scr2_pxl), 32'd0);
        check_eq("mid rst col", 32'(scr2col), 32'd0);
        check_eq("mid rst enb", 32'(scr2enb), 32'd0);
`ifdef JTVIGIL_SCR2_DEBUG_EN
        check_eq("mid rst st_dout", 32'(st_dout), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("post rst idle", 32'(rom_if.rom_cs), 32'd0);
        LHBL = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post rst idle hi", 32'(rom_if.rom_cs), 32'd0);
        run_line(8'd3, 11'h000, 16, -1, 99, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
